// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-addressed multi-cycle data memory (byte/half/word, sign/zero-extended loads).
// Latency: LATENCY wait cycles after acceptance, then a one-cycle done pulse; misaligned -> err next cycle.
// Backpressure: busy is high while an access waits; req is only sampled in IDLE or RESP.
// Ports: clk/rst_n; request fields req/we/size/sign_ext/addr/wr_data; results rd_data/busy/done/err.
module dmem_bytelane #(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 128,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wr_data,
    output logic [31:0]           rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [31:0]        rd_data_q, rd_data_d;

    // Request fields latched at acceptance, used when the access completes out of WAIT.
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               sign_q, sign_d;
    logic [IDX_W+1:0]   addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;

    logic [31:0]        mem [MEM_WORDS];

    // Address bits above the array size are ignored so addresses wrap.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDR_WIDTH-1:IDX_W+2];

    logic               can_accept;
    logic               misaligned;
    logic               in_wait;
    logic               do_access;
    logic               mem_we;

    logic               acc_we;
    logic [1:0]         acc_size;
    logic               acc_sign;
    logic [IDX_W+1:0]   acc_addr;
    logic [31:0]        acc_wdata;
    logic [IDX_W-1:0]   acc_idx;

    logic [31:0]        mem_rdata;
    logic [31:0]        shifted;
    logic [15:0]        half_sel;
    logic [31:0]        load_val;
    logic [3:0]         st_be;
    logic [31:0]        st_data;

    assign can_accept = req && (state_q == S_IDLE || state_q == S_RESP);
    assign in_wait    = (state_q == S_WAIT);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // With zero latency the access completes on the acceptance edge itself, so the
    // live request fields are used; otherwise the latched copy drives the access.
    assign acc_we    = in_wait ? we_q    : we;
    assign acc_size  = in_wait ? size_q  : size;
    assign acc_sign  = in_wait ? sign_q  : sign_ext;
    assign acc_addr  = in_wait ? addr_q  : addr[IDX_W+1:0];
    assign acc_wdata = in_wait ? wdata_q : wr_data;
    assign acc_idx   = acc_addr[IDX_W+1:2];

    assign do_access = (in_wait && cnt_q == 4'd1) ||
                       (can_accept && !misaligned && LATENCY == 0);
    assign mem_we    = do_access && acc_we && rst_n;

    // Load path: pick lane(s), then sign- or zero-extend from the selected MSB.
    assign mem_rdata = mem[acc_idx];
    assign shifted   = mem_rdata >> {acc_addr[1:0], 3'b000};
    assign half_sel  = acc_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_val = mem_rdata;
        case (acc_size)
            2'b00:   load_val = {{24{acc_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{acc_sign & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata;
        endcase
    end

    // Store path: replicate right-justified data across lanes, enable only the target lanes.
    always_comb begin
        st_be   = 4'b1111;
        st_data = acc_wdata;
        case (acc_size)
            2'b00: begin
                st_be   = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = acc_wdata;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        rd_data_d = rd_data_q;
        we_d      = we_q;
        size_d    = size_q;
        sign_d    = sign_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (can_accept) begin
                    we_d    = we;
                    size_d  = size;
                    sign_d  = sign_ext;
                    addr_d  = addr[IDX_W+1:0];
                    wdata_d = wr_data;
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else if (LATENCY == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access && !acc_we) begin
            rd_data_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            rd_data_q <= 32'd0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            we_q      <= we_d;
            size_q    <= size_d;
            sign_q    <= sign_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = (state_q == S_WAIT);
    assign done    = (state_q == S_RESP);
    assign err     = err_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Testbench for dmem_bytelane: three instances with LATENCY 2, 0 and 3.
// Table-driven accesses plus back-to-back and reset-abort sequences, scoreboard of expected completions.
// Summary line reports comparisons made and failures.
module tb_dmem_bytelane;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [NDUT];
    logic        req      [NDUT];
    logic        we       [NDUT];
    logic [1:0]  size     [NDUT];
    logic        sign_ext [NDUT];
    logic [31:0] addr     [NDUT];
    logic [31:0] wr_data  [NDUT];
    logic [31:0] rd_data  [NDUT];
    logic        busy     [NDUT];
    logic        done     [NDUT];
    logic        err      [NDUT];

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
    endfunction

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            dmem_bytelane #(
                .ADDR_WIDTH(32),
                .MEM_WORDS (128),
                .LATENCY   ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
            ) u_dut (
                .clk     (clk),
                .rst_n   (rst_n[g]),
                .req     (req[g]),
                .we      (we[g]),
                .size    (size[g]),
                .sign_ext(sign_ext[g]),
                .addr    (addr[g]),
                .wr_data (wr_data[g]),
                .rd_data (rd_data[g]),
                .busy    (busy[g]),
                .done    (done[g]),
                .err     (err[g])
            );
        end
    endgenerate

    typedef struct {
        int          d;
        bit          is_err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        bit          w;
        logic [1:0]  sz;
        bit          sx;
        logic [31:0] a;
        logic [31:0] wd;
        bit          e;
        logic [31:0] rd;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    vec_t b2b[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Pop and compare the oldest expected completion whenever a DUT reports done or err.
    task automatic sample(input int d);
        exp_t e;
        if (done[d] === 1'b1 || err[d] === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: dut %0d completed, expected no completion", d);
            end else begin
                e = sbq.pop_front();
                chk("sb_dut", d, e.d);
                chk("sb_kind", {30'd0, err[d], done[d]}, e.is_err ? 32'd2 : 32'd1);
                chk("sb_rd", rd_data[d], e.rd);
            end
        end
    endtask

    task automatic drive(input int d, input bit r, input vec_t v);
        req[d]      = r;
        we[d]       = v.w;
        size[d]     = v.sz;
        sign_ext[d] = v.sx;
        addr[d]     = v.a;
        wr_data[d]  = v.wd;
    endtask

    function automatic vec_t mk(input bit w, input logic [1:0] sz, input bit sx,
                                input logic [31:0] a, input logic [31:0] wd,
                                input bit e, input logic [31:0] rd);
        vec_t v;
        v.w = w; v.sz = sz; v.sx = sx; v.a = a; v.wd = wd; v.e = e; v.rd = rd;
        return v;
    endfunction

    // One isolated access with full cycle-by-cycle handshake checks.
    task automatic xfer(input int d, input vec_t v);
        int lat;
        lat = lat_of(d);
        sbq.push_back('{d, v.e, v.rd});
        @(posedge clk); #1;
        drive(d, 1'b1, v);
        @(posedge clk); #1;
        req[d] = 1'b0;
        if (v.e) begin
            @(negedge clk);
            chk("err_pulse", {31'd0, err[d]}, 32'd1);
            chk("err_busy", {31'd0, busy[d]}, 32'd0);
            chk("err_done", {31'd0, done[d]}, 32'd0);
            sample(d);
            @(negedge clk);
            chk("err_one_cycle", {31'd0, err[d]}, 32'd0);
        end else begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                chk("wait_busy", {31'd0, busy[d]}, 32'd1);
                chk("wait_done", {31'd0, done[d]}, 32'd0);
                sample(d);
            end
            @(negedge clk);
            chk("resp_done", {31'd0, done[d]}, 32'd1);
            chk("resp_busy", {31'd0, busy[d]}, 32'd0);
            sample(d);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done[d]}, 32'd0);
            sample(d);
        end
    endtask

    initial begin
        logic [31:0] cur_rd;
        vec_t        v;

        for (int d = 0; d < NDUT; d++) begin
            rst_n[d] = 1'b0;
            drive(d, 1'b0, mk(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0));
        end
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_rd_data", rd_data[d], 32'd0);
            chk("rst_busy", {31'd0, busy[d]}, 32'd0);
            chk("rst_done", {31'd0, done[d]}, 32'd0);
            chk("rst_err", {31'd0, err[d]}, 32'd0);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) rst_n[d] = 1'b1;

        // LATENCY=2 table: {we, size, sign, addr, wdata, expect_err, expect_rd_data}
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h00000000));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2'b10, 0, 32'h10, 32'h11223344, 0, 32'hDEADBEEF));
        vecs.push_back(mk(1, 2'b00, 0, 32'h13, 32'h12345680, 0, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h80223344));
        vecs.push_back(mk(0, 2'b00, 1, 32'h13, 32'h0,        0, 32'hFFFFFF80));
        vecs.push_back(mk(0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000080));
        vecs.push_back(mk(1, 2'b10, 0, 32'h14, 32'h55667788, 0, 32'h00000080));
        vecs.push_back(mk(1, 2'b01, 0, 32'h16, 32'h1234A5A5, 0, 32'h00000080));
        vecs.push_back(mk(0, 2'b01, 1, 32'h16, 32'h0,        0, 32'hFFFFA5A5));
        vecs.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0,        0, 32'hA5A57788));
        vecs.push_back(mk(0, 2'b01, 0, 32'h14, 32'h0,        0, 32'h00007788));
        vecs.push_back(mk(0, 2'b00, 1, 32'h12, 32'h0,        0, 32'h00000022));
        vecs.push_back(mk(0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h00000033));
        vecs.push_back(mk(0, 2'b10, 0, 32'h02, 32'h0,        1, 32'h00000033));
        vecs.push_back(mk(1, 2'b01, 0, 32'h05, 32'hFFFF,     1, 32'h00000033));
        vecs.push_back(mk(1, 2'b01, 0, 32'h15, 32'hFFFF,     1, 32'h00000033));
        vecs.push_back(mk(1, 2'b11, 0, 32'h10, 32'h0,        1, 32'h00000033));
        vecs.push_back(mk(0, 2'b10, 0, 32'h14, 32'h0,        0, 32'hA5A57788));
        vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h80223344));
        vecs.push_back(mk(0, 2'b01, 0, 32'h12, 32'h0,        0, 32'h00008022));
        vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0,        0, 32'hFFFF8022));
        for (int i = 0; i < vecs.size(); i++) xfer(0, vecs[i]);

        // LATENCY=0: back-to-back stores then loads, aliasing and store-then-load.
        cur_rd = 32'd0;
        for (int i = 0; i < 8; i++)
            b2b.push_back(mk(1, 2'b10, 0, 32'(4*i), 32'hC0DE0000 | 32'(i), 0, cur_rd));
        for (int i = 0; i < 8; i++) begin
            cur_rd = 32'hC0DE0000 | 32'(i);
            b2b.push_back(mk(0, 2'b10, 0, 32'(4*i), 32'h0, 0, cur_rd));
        end
        b2b.push_back(mk(0, 2'b10, 0, 32'h200, 32'h0, 0, 32'hC0DE0000));
        b2b.push_back(mk(1, 2'b10, 0, 32'h204, 32'hBEEF0001, 0, 32'hC0DE0000));
        b2b.push_back(mk(0, 2'b10, 0, 32'h04, 32'h0, 0, 32'hBEEF0001));
        @(posedge clk);
        for (int i = 0; i < b2b.size(); i++) begin
            #1;
            sbq.push_back('{1, 1'b0, b2b[i].rd});
            drive(1, 1'b1, b2b[i]);
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_done", {31'd0, done[1]}, 32'd1);
                sample(1);
            end
            @(posedge clk);
        end
        #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("b2b_done_last", {31'd0, done[1]}, 32'd1);
        sample(1);
        @(negedge clk);
        chk("b2b_idle", {31'd0, done[1]}, 32'd0);

        // LATENCY=3: reset pulse during WAIT aborts a store.
        xfer(2, mk(1, 2'b10, 0, 32'h20, 32'h11111111, 0, 32'h00000000));
        xfer(2, mk(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h11111111));
        v = mk(1, 2'b10, 0, 32'h20, 32'h22222222, 0, 32'h0);
        @(posedge clk); #1;
        drive(2, 1'b1, v);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy[2]}, 32'd1);
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        chk("abort_busy_clr", {31'd0, busy[2]}, 32'd0);
        chk("abort_done_clr", {31'd0, done[2]}, 32'd0);
        chk("abort_err_clr", {31'd0, err[2]}, 32'd0);
        chk("abort_rd_clr", rd_data[2], 32'd0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done[2]}, 32'd0);
            sample(2);
        end
        xfer(2, mk(0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h11111111));

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Byte-addressed, multi-cycle data memory for the MIPS32 pipeline MEM stage. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. A parametrised access latency and a busy/done handshake let the pipeline stall on memory. Misaligned accesses are rejected with an error pulse, and memory is left untouched.

## Interface
- ADDR_WIDTH, 32, width of the byte address
- MEM_WORDS, 128, number of 32-bit words; power of two, ≥ 4
- LATENCY, 1, wait cycles between acceptance and completion; legal range 0..15
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- req  input  1  access request, sampled only when the block is idle or responding
- we  input  1  1 = store, 0 = load; sampled with req
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal; sampled with req
- sign_ext  input  1  1 = sign-extend sub-word loads, 0 = zero-extend; sampled with req
- addr  input  ADDR_WIDTH  byte address; sampled with req
- wr_data  input  32  store data, right-justified (byte in [7:0], half in [15:0]); sampled with req
- rd_data  output  32  load result, registered; holds its value until the next load completes
- busy  output  1  high while an accepted access is waiting; the pipeline stalls on it
- done  output  1  one-cycle pulse when an accepted access completes
- err  output  1  one-cycle pulse when a request is rejected as misaligned

## Operation
- Storage: MEM_WORDS × 32-bit array, little-endian lanes.
  - Byte lane k maps to bits [8k+7:8k], with k = addr[1:0].
  - Word index = addr[$clog2(MEM_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
- Array contents are not reset.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting down LATENCY cycles.
  - RESP: access completed; done is high.
- Acceptance happens in IDLE or RESP when req=1. The request fields are latched.
- Alignment check at acceptance:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
  - size=11 is always illegal.
- Misaligned request:
  - Next cycle: err=1, done=0, busy=0, and the state returns to IDLE.
  - No array write occurs; rd_data is unchanged.
- Aligned request with LATENCY=0: next state is RESP.
- Aligned request with LATENCY>0: next state is WAIT, with the counter loaded to LATENCY.
- WAIT: the counter decrements each cycle. On the edge where the counter equals 1, the state goes to RESP. req is ignored throughout WAIT.
- The access is performed on the edge that enters RESP:
  - Store byte: only lane k is written.
  - Store half: lanes {2·addr[1]+1, 2·addr[1]} are written.
  - Store word: all lanes are written. Unselected lanes keep their contents.
  - Load: the selected byte or half is extracted into the low bits. The upper bits are filled with the selected data's MSB if sign_ext=1, else with 0.
  - A store leaves rd_data unchanged.
- RESP: done=1 for exactly one cycle. A new req in this cycle is accepted, giving back-to-back operation; otherwise the state returns to IDLE.

## Timing
- Request high in cycle 0 (state IDLE or RESP):
  - busy is high in cycles 1..LATENCY.
  - done is high in cycle 1+LATENCY.
  - The write to the array and the update of rd_data land on the edge that starts cycle 1+LATENCY.
  - Hence a load to the address of a just-completed store returns the new data.
- Minimum throughput: one access per 1+LATENCY cycles. With LATENCY=0, one access per cycle.
- busy, done and err are decoded from registered state; none of them combinationally depends on req.
- Reset values (rst_n low, immediately and asynchronously): state IDLE, counter 0, busy 0, done 0, err 0, rd_data 0.
- Reset asserted during WAIT aborts the access: no write occurs and no done pulse is produced.
- Reset asserted in the RESP cycle clears done immediately. A write already performed on the entry edge remains in the array.
- err and done are never high in the same cycle.

## Test plan
- LATENCY=2: store word 0xDEADBEEF at addr 0x10, then load word at 0x10 → busy high 2 cycles, done in cycle 3 of each access, rd_data=0xDEADBEEF.
- Store byte 0x80 at 0x13 over word 0x11223344 at 0x10:
  - Load word at 0x10 returns 0x80223344.
  - Load byte signed at 0x13 returns 0xFFFFFF80.
  - Load byte unsigned at 0x13 returns 0x00000080.
- Store half 0xA5A5 at 0x16, then load half signed at 0x16 → 0xFFFFA5A5. Word 0x14 keeps its lanes 0–1 unchanged.
- Misaligned requests: load word at 0x02, store half at 0x05, and size=11 at 0x00 → err pulse in cycle 1, no busy, no done, array and rd_data unchanged.
- LATENCY=0, back-to-back requests every cycle to addresses 0x00..0x1C → done every cycle. Address 4·MEM_WORDS aliases to word 0.
- LATENCY=3: store accepted, then rst_n pulsed low during WAIT → outputs zero at once, no done pulse, target word holds its old value.
